// File: rtl/spi_master_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_master_mc - byte-wide SPI mode-0 master: runtime divider, multi-CS, CS hold.
// Optional dummy-clock init sequence: define SPI_INIT_CLOCKS_EN.   Rev 1.0
// ----------------------------------------------------------------------------
module spi_master_mc #(
    parameter int CS_COUNT    = 2,
    parameter int CS_W        = 1,
    parameter int DIV_W       = 8,
    parameter int INIT_CLOCKS = 80
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DIV_W-1:0]    divider,
    input  logic [CS_W-1:0]     cs_sel,
    input  logic                cs_hold,
    input  logic [7:0]          tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [7:0]          rx_data,
    output logic                rx_valid,
    output logic                busy,
    input  logic                init_start,
    output logic                init_done,
    output logic                spi_sclk,
    output logic                spi_mosi,
    input  logic                spi_miso,
    output logic [CS_COUNT-1:0] spi_cs
);

    localparam int HALF_W = (2 * INIT_CLOCKS > 16) ? $clog2(2 * INIT_CLOCKS) : 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_SETUP,
        ST_SHIFT
`ifdef SPI_INIT_CLOCKS_EN
        , ST_INIT
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic [DIV_W-1:0]      hdiv_q, hdiv_d;
    logic [HALF_W-1:0]     half_q, half_d;
    logic [CS_W-1:0]       sel_q, sel_d;
    logic                  hold_q, hold_d;
    logic                  held_q, held_d;
    logic [7:0]            tx_q, tx_d;
    logic [7:0]            rx_q, rx_d;
    logic [7:0]            rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  init_done_q, init_done_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic [CS_COUNT-1:0]   cs_q, cs_d;

    // Out-of-range selects decode to no active chip select.
    function automatic logic [CS_COUNT-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [CS_COUNT-1:0] v;
        v = '1;
        for (int i = 0; i < CS_COUNT; i++) begin
            if (int'(sel) == i) v[i] = 1'b0;
        end
        return v;
    endfunction

`ifdef SPI_INIT_CLOCKS_EN
    assign tx_ready = (state_q == ST_IDLE) && !init_start;
`else
    logic unused_init_start;
    assign unused_init_start = init_start;
    assign tx_ready = (state_q == ST_IDLE);
`endif

    assign busy      = (state_q != ST_IDLE);
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign init_done = init_done_q;
    assign spi_sclk  = sclk_q;
    assign spi_mosi  = mosi_q;
    assign spi_cs    = cs_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hdiv_q      <= '0;
            half_q      <= '0;
            sel_q       <= '0;
            hold_q      <= 1'b0;
            held_q      <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b1;
            cs_q        <= '1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hdiv_q      <= hdiv_d;
            half_q      <= half_d;
            sel_q       <= sel_d;
            hold_q      <= hold_d;
            held_q      <= held_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            init_done_q <= init_done_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_q        <= cs_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hdiv_d      = hdiv_q;
        half_d      = half_q;
        sel_d       = sel_q;
        hold_d      = hold_q;
        held_d      = held_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        init_done_d = 1'b0;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_d        = cs_q;

        case (state_q)
            ST_IDLE: begin
`ifdef SPI_INIT_CLOCKS_EN
                if (init_start) begin
                    state_d = ST_INIT;
                    hdiv_d  = divider;
                    cnt_d   = divider;
                    half_d  = '0;
                    cs_d    = '1;
                    held_d  = 1'b0;
                    mosi_d  = 1'b1;
                    sclk_d  = 1'b0;
                end else
`endif
                if (tx_valid) begin
                    hdiv_d = divider;
                    cnt_d  = divider;
                    half_d = '0;
                    sel_d  = cs_sel;
                    hold_d = cs_hold;
                    tx_d   = tx_data;
                    // A held CS either continues straight into SHIFT or must be released first.
                    if (held_q && (sel_q == cs_sel)) begin
                        state_d = ST_SHIFT;
                        mosi_d  = tx_data[7];
                    end else if (held_q) begin
                        state_d = ST_GAP;
                        cs_d    = '1;
                        held_d  = 1'b0;
                    end else begin
                        state_d = ST_SETUP;
                        cs_d    = cs_decode(cs_sel);
                        mosi_d  = tx_data[7];
                    end
                end
            end

            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_SETUP;
                    cnt_d   = hdiv_q;
                    cs_d    = cs_decode(sel_q);
                    mosi_d  = tx_q[7];
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end

            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_SHIFT;
                    cnt_d   = hdiv_q;
                    half_d  = '0;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end

            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    cnt_d = hdiv_q;
                    if (half_q == HALF_W'(15)) begin
                        state_d    = ST_IDLE;
                        sclk_d     = 1'b0;
                        mosi_d     = 1'b1;
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_q;
                        held_d     = hold_q;
                        if (!hold_q) cs_d = '1;
                    end else begin
                        half_d = half_q + HALF_W'(1);
                        sclk_d = ~sclk_q;
                        if (!sclk_q) begin
                            rx_d = {rx_q[6:0], spi_miso};
                        end else begin
                            tx_d   = {tx_q[6:0], 1'b0};
                            mosi_d = tx_q[6];
                        end
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end

`ifdef SPI_INIT_CLOCKS_EN
            ST_INIT: begin
                if (cnt_q == '0) begin
                    cnt_d = hdiv_q;
                    if (half_q == HALF_W'(2 * INIT_CLOCKS - 1)) begin
                        state_d     = ST_IDLE;
                        sclk_d      = 1'b0;
                        init_done_d = 1'b1;
                    end else begin
                        half_d = half_q + HALF_W'(1);
                        sclk_d = ~sclk_q;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
`endif

            default: state_d = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_mc.sv
`default_nettype none
// tb_spi_master_mc: scoreboard bench for spi_master_mc; directed transfers with hand-computed results.
module tb_spi_master_mc;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] divider = '0;
    logic [1:0] cs_sel = '0;
    logic       cs_hold = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       init_start = 1'b0;
    logic       init_done;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso = 1'b1;
    logic [1:0] spi_cs;

    spi_master_mc #(
        .CS_COUNT(2), .CS_W(2), .DIV_W(8), .INIT_CLOCKS(80)
    ) dut (
        .clock(clock), .reset(reset), .divider(divider), .cs_sel(cs_sel),
        .cs_hold(cs_hold), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .init_start(init_start), .init_done(init_done),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs(spi_cs)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  rx;
        logic [7:0]  tx;
        int unsigned lat;
        int unsigned c0;
        logic [1:0]  cs;
    } item_t;

    item_t sb[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave model: mode 0, presents MSB first and shifts on falling SCLK.
    logic [7:0] slave_q = '0;
    logic [7:0] mosi_cap = '0;
    always @(posedge spi_sclk) mosi_cap <= {mosi_cap[6:0], spi_mosi};
    always @(negedge spi_sclk) begin
        slave_q  = {slave_q[6:0], 1'b0};
        spi_miso = slave_q[7];
    end

    // Monitor: every rx_valid pulse must match the oldest outstanding transfer.
    always @(negedge clock) begin
        if (rx_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rx_valid: got rx_valid=1 rx_data=%0h expected no pulse", rx_data);
            end else begin
                item_t it;
                it = sb.pop_front();
                chk("rx_data", rx_data, it.rx);
                chk("latency", cyc - it.c0, it.lat);
                chk("mosi_bits", mosi_cap, it.tx);
                chk("cs_at_done", spi_cs, it.cs);
            end
        end
    end

    logic watch = 1'b0, glitch = 1'b0;
    always @(negedge clock) if (watch && busy && spi_cs[0]) glitch = 1'b1;

    logic init_mon = 1'b0, init_bad = 1'b0;
    int   init_cnt = 0;
    always @(posedge spi_sclk) if (init_mon) init_cnt++;
    always @(negedge clock) if (init_mon && busy && (spi_cs !== 2'b11 || spi_mosi !== 1'b1)) init_bad = 1'b1;

    task automatic send(input logic [1:0] sel, input logic hold, input logic [7:0] div,
                        input logic [7:0] data, input logic [7:0] sl, input int unsigned lat,
                        input logic [1:0] cs_done, input bit track);
        int n;
        n = 0;
        @(negedge clock);
        while (!tx_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!tx_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got tx_ready=0 expected 1");
            return;
        end
        cs_sel   = sel;
        cs_hold  = hold;
        divider  = div;
        tx_data  = data;
        tx_valid = 1'b1;
        slave_q  = sl;
        spi_miso = sl[7];
        if (track) sb.push_back('{rx: sl, tx: data, lat: lat, c0: cyc, cs: cs_done});
        @(posedge clock);
        #1 tx_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < maxc) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0 || busy) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got pending=%0d busy=%0b expected 0 0", sb.size(), busy);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned c0;
        int n;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_sclk", spi_sclk, 1'b0);
        chk("rst_mosi", spi_mosi, 1'b1);
        chk("rst_cs", spi_cs, 2'b11);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_tx_ready", tx_ready, 1'b1);

        // Fresh CS, H=2: rx_valid at 17H+1 = 35.
        send(2'd0, 1'b0, 8'd1, 8'hA5, 8'h3C, 35, 2'b11, 1'b1);
        @(negedge clock);
        chk("fresh_cs_cycle1", spi_cs, 2'b10);
        drain(200);

        // Held CS back-to-back, H=1: 18 then 16H+1 = 17.
        send(2'd0, 1'b1, 8'd0, 8'hFF, 8'h81, 18, 2'b10, 1'b1);
        glitch = 1'b0;
        watch  = 1'b1;
        send(2'd0, 1'b0, 8'd0, 8'h00, 8'h7E, 17, 2'b11, 1'b1);
        drain(100);
        watch = 1'b0;
        chk("held_cs_continuous", glitch, 1'b0);

        // CS switch, H=1: GAP one cycle, then CS1, rx_valid at 19.
        send(2'd0, 1'b1, 8'd0, 8'h12, 8'h34, 18, 2'b10, 1'b1);
        send(2'd1, 1'b0, 8'd0, 8'h56, 8'h9A, 19, 2'b11, 1'b1);
        @(negedge clock);
        chk("switch_gap_cs", spi_cs, 2'b11);
        @(negedge clock);
        chk("switch_new_cs", spi_cs, 2'b01);
        drain(100);

        // Out-of-range select, plus a request while busy that must be dropped.
        send(2'd3, 1'b0, 8'd1, 8'hC3, 8'h5A, 35, 2'b11, 1'b1);
        @(negedge clock);
        chk("oor_cs", spi_cs, 2'b11);
        chk("oor_busy", busy, 1'b1);
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        drain(200);
        repeat (40) @(negedge clock);

`ifdef SPI_INIT_CLOCKS_EN
        @(negedge clock);
        divider    = 8'd0;
        cs_sel     = 2'd0;
        cs_hold    = 1'b0;
        tx_data    = 8'hE7;
        tx_valid   = 1'b1;
        init_start = 1'b1;
        #1;
        chk("init_blocks_tx_ready", tx_ready, 1'b0);
        c0       = cyc;
        init_cnt = 0;
        init_bad = 1'b0;
        init_mon = 1'b1;
        @(posedge clock);
        #1 init_start = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!init_done && n < 400);
        init_mon = 1'b0;
        chk("init_done_seen", init_done, 1'b1);
        chk("init_done_latency", cyc - c0, 161);
        chk("init_pulses", init_cnt, 80);
        chk("init_cs_mosi_idle", init_bad, 1'b0);
        // Pending request is accepted on the init_done cycle.
        slave_q  = 8'h42;
        spi_miso = 1'b0;
        sb.push_back('{rx: 8'h42, tx: 8'hE7, lat: 18, c0: cyc, cs: 2'b11});
        @(posedge clock);
        #1 tx_valid = 1'b0;
        drain(100);
`else
        @(negedge clock);
        init_start = 1'b1;
        #1;
        chk("noinit_tx_ready", tx_ready, 1'b1);
        @(negedge clock);
        chk("noinit_busy", busy, 1'b0);
        chk("noinit_done", init_done, 1'b0);
        init_start = 1'b0;
`endif

        // Reset in the middle of SHIFT (H=4): SETUP 1..4, SHIFT from 5, high half at 9..12.
        send(2'd0, 1'b0, 8'd3, 8'h77, 8'hAA, 0, 2'b11, 1'b0);
        repeat (9) @(negedge clock);
        chk("pre_reset_cs", spi_cs, 2'b10);
        chk("pre_reset_sclk", spi_sclk, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("midreset_cs", spi_cs, 2'b11);
        chk("midreset_sclk", spi_sclk, 1'b0);
        chk("midreset_busy", busy, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_tx_ready", tx_ready, 1'b1);
        repeat (80) @(negedge clock);
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
